// File: rtl/mem_streamer_if.sv
// Bus between the memory streamer, its synchronous-read MEM and the UART transmitter.
// The master modport is the streamer's view; slave is the environment's view.
interface mem_streamer_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic [ADDR_W-1:0] read_select;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, length, read_data, tx_ready,
        output read_select, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, base_addr, length, read_data, tx_ready,
        input  read_select, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/mem_streamer.sv
// Streams a block of bytes out of a synchronous-read MEM into a UART transmitter,
// one valid/ready handshake per byte, in ascending address order.
module mem_streamer #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_streamer_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              done_q;

    // The MEM answers one clk after the address; capturing again in LOAD makes sure
    // the byte held in SEND is the one for the current address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            count      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.length != '0) begin
                            addr  <= bus.base_addr;
                            count <= bus.length;
                            state <= FETCH;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                FETCH: begin
                    tx_data_q <= bus.read_data;
                    state     <= LOAD;
                end
                LOAD: begin
                    tx_data_q  <= bus.read_data;
                    tx_valid_q <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (tx_valid_q && bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (count > ADDR_W'(1)) begin
                            addr  <= addr + ADDR_W'(1);
                            count <= count - ADDR_W'(1);
                            state <= FETCH;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The address register itself is the MEM read address, so it wraps with addr.
    assign bus.read_select = addr;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_mem_streamer.sv
// Self-checking bench for mem_streamer: table-driven and random dumps against a
// queue-based model of the bytes each dump must emit, plus hand-written corner cases.
module tb_mem_streamer;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read MEM: data appears one clk after the address.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) bus.read_data <= mem[bus.read_select];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] got [$];

    typedef struct {
        int base;
        int len;
        int ready_pct;
        bit noise;
        int exp_bytes;
        int exp_done;
        int exp_latency;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input int b, input int l, input logic r);
        bus.start     = s;
        bus.base_addr = b[ADDR_W-1:0];
        bus.length    = l[ADDR_W-1:0];
        bus.tx_ready  = r;
    endtask

    // One clock: record a handshake about to happen, then sample 1ns after the edge.
    task automatic cycle();
        logic stall;
        logic [DATA_W-1:0] held;
        stall = bus.tx_valid && !bus.tx_ready;
        held  = bus.tx_data;
        if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
        @(posedge clk);
        #1;
        if (bus.done) done_cnt++;
        if (stall && !rst) begin
            checkOutput("hold_valid", bus.tx_valid, 1);
            checkOutput("hold_data", bus.tx_data, held);
        end
    endtask

    task automatic waitDone(input int budget, output bit seen);
        int n;
        n = 0;
        seen = bus.done;
        while (!seen && n < budget) begin
            applyStimulus(0, 0, 0, 1);
            cycle();
            n++;
            seen = bus.done;
        end
    endtask

    task automatic runDump(input int base, input int len, input int ready_pct, input bit noise,
                           input int exp_bytes, input int exp_done, input int exp_latency);
        int lat;
        bit seen;
        logic [DATA_W-1:0] exp_q [$];
        got.delete();
        done_cnt = 0;
        for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
        applyStimulus(1, base, len, 1);
        cycle();
        lat = 1;
        checkOutput("busy_after_start", bus.busy, 1);
        seen = bus.done;
        while (!seen && lat < 3000) begin
            applyStimulus(noise && ($urandom_range(1, 0) == 1), $urandom_range(DEPTH - 1, 0),
                          $urandom_range(5, 0), $urandom_range(99, 0) < ready_pct);
            cycle();
            lat++;
            seen = bus.done;
        end
        checkOutput("done_seen", seen, 1);
        if (exp_latency != 0) checkOutput("latency", lat, exp_latency);
        checkOutput("tx_valid_in_done", bus.tx_valid, 0);
        // A start presented while in DONE must not begin a new dump.
        applyStimulus(noise, base + 7, 3, 1);
        cycle();
        checkOutput("busy_after_done", bus.busy, 0);
        checkOutput("done_one_cycle", bus.done, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("byte_count", got.size(), exp_bytes);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            checkOutput("byte_value", got[i], exp_q[i]);
        checkOutput("done_count", done_cnt, exp_done);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        bit seen;
        int base;
        int len;
        int rp;
        bit noise;

        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        mem[1] = 8'h09;
        mem[2] = 8'h41;
        mem[3] = 8'h42;

        vecs[0] = '{base: 1,     len: 3, ready_pct: 100, noise: 0, exp_bytes: 3, exp_done: 1, exp_latency: 10};
        vecs[1] = '{base: 16383, len: 2, ready_pct: 100, noise: 0, exp_bytes: 2, exp_done: 1, exp_latency: 7};
        vecs[2] = '{base: 0,     len: 0, ready_pct: 100, noise: 1, exp_bytes: 0, exp_done: 1, exp_latency: 1};
        vecs[3] = '{base: 100,   len: 5, ready_pct: 100, noise: 1, exp_bytes: 5, exp_done: 1, exp_latency: 16};
        vecs[4] = '{base: 16380, len: 6, ready_pct: 40,  noise: 1, exp_bytes: 6, exp_done: 1, exp_latency: 0};

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_read_select", bus.read_select, 0);
        checkOutput("reset_tx_data", bus.tx_data, 0);
        checkOutput("reset_tx_valid", bus.tx_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Known-content dump: 9, 0x41, 0x42 emitted three clocks apart.
        got.delete();
        done_cnt = 0;
        applyStimulus(1, 1, 3, 1);
        cycle();
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cycle();
        checkOutput("known_byte_count", got.size(), 3);
        if (got.size() == 3) begin
            checkOutput("known_byte0", got[0], 8'h09);
            checkOutput("known_byte1", got[1], 8'h41);
            checkOutput("known_byte2", got[2], 8'h42);
        end
        checkOutput("known_done", bus.done, 1);
        cycle();
        checkOutput("known_busy_low", bus.busy, 0);
        checkOutput("known_done_count", done_cnt, 1);

        for (int v = 0; v < 5; v++)
            runDump(vecs[v].base, vecs[v].len, vecs[v].ready_pct, vecs[v].noise,
                    vecs[v].exp_bytes, vecs[v].exp_done, vecs[v].exp_latency);

        // Address wrap: read_select goes 16383 then 0.
        applyStimulus(1, 16383, 2, 1);
        cycle();
        checkOutput("wrap_sel_first", bus.read_select, 16383);
        applyStimulus(0, 0, 0, 1);
        cycle();
        cycle();
        checkOutput("wrap_byte_first", bus.tx_data, mem[16383]);
        cycle();
        checkOutput("wrap_sel_second", bus.read_select, 0);
        cycle();
        cycle();
        checkOutput("wrap_byte_second", bus.tx_data, mem[0]);
        waitDone(50, seen);
        checkOutput("wrap_done", seen, 1);
        cycle();

        // Transmitter stalls five clocks in SEND; the byte must be held.
        got.delete();
        applyStimulus(1, 50, 1, 0);
        cycle();
        applyStimulus(0, 0, 0, 0);
        cycle();
        cycle();
        checkOutput("stall_valid", bus.tx_valid, 1);
        checkOutput("stall_data", bus.tx_data, mem[50]);
        for (int i = 0; i < 5; i++) cycle();
        checkOutput("stall_still_valid", bus.tx_valid, 1);
        applyStimulus(0, 0, 0, 1);
        cycle();
        checkOutput("stall_released", bus.tx_valid, 0);
        checkOutput("stall_count", got.size(), 1);
        if (got.size() == 1) checkOutput("stall_byte", got[0], mem[50]);
        waitDone(50, seen);
        checkOutput("stall_done", seen, 1);
        cycle();

        // Asynchronous reset in the middle of a three-byte dump.
        got.delete();
        done_cnt = 0;
        applyStimulus(1, 20, 3, 1);
        cycle();
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle();
        checkOutput("pre_reset_bytes", got.size(), 1);
        checkOutput("pre_reset_valid", bus.tx_valid, 1);
        checkOutput("pre_reset_busy", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_tx_valid", bus.tx_valid, 0);
        checkOutput("async_busy", bus.busy, 0);
        checkOutput("async_read_select", bus.read_select, 0);
        checkOutput("async_tx_data", bus.tx_data, 0);
        checkOutput("async_done", bus.done, 0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        checkOutput("no_done_after_reset", done_cnt, 0);
        checkOutput("idle_after_reset", bus.busy, 0);
        runDump(20, 3, 100, 0, 3, 1, 10);

        // Random dumps against the model.
        for (int n = 0; n < 15; n++) begin
            base  = ($urandom_range(3, 0) == 0) ? $urandom_range(DEPTH - 1, DEPTH - 4) : $urandom_range(DEPTH - 1, 0);
            len   = $urandom_range(8, 0);
            rp    = ($urandom_range(1, 0) == 1) ? 100 : $urandom_range(90, 30);
            noise = $urandom_range(1, 0) == 1;
            runDump(base, len, rp, noise, len, 1, (rp == 100) ? 3 * len + 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_streamer.md
MEM_STREAMER -- requirements
Module: mem_streamer

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the MEM address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the MEM data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a dump; ignored while busy.
REQ-006 base_addr  input  ADDR_W  SHALL be the first MEM address, sampled when start is accepted.
REQ-007 length  input  ADDR_W  SHALL be the byte count, sampled when start is accepted; 0 is legal.
REQ-008 read_select  output  ADDR_W  SHALL drive the MEM read address.
REQ-009 read_data  input  DATA_W  SHALL be MEM read data, valid one clk after read_select is presented.
REQ-010 tx_data  output  DATA_W  SHALL be the byte offered to the UART transmitter.
REQ-011 tx_valid  output  1  SHALL indicate that tx_data holds a byte awaiting acceptance.
REQ-012 tx_ready  input  1  SHALL indicate that the transmitter accepts tx_data this cycle.
REQ-013 busy  output  1  SHALL be high from start acceptance until done is asserted.
REQ-014 done  output  1  SHALL pulse high for exactly one clk when a dump completes.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, LOAD, SEND and DONE.
REQ-016 IDLE: start=1 with length!=0 -> latch addr=base_addr, count=length, drive read_select=base_addr, go FETCH; busy=1 the next cycle.
REQ-017 IDLE: start=1 with length=0 -> go DONE with busy=1, never assert tx_valid, pulse done the following cycle.
REQ-018 FETCH: the next clk samples read_data into tx_data and goes to LOAD.
REQ-019 LOAD: the next clk asserts tx_valid and goes to SEND; tx_data is registered (one-cycle bubble for MEM sync read).
REQ-020 SEND: tx_valid and tx_data SHALL stay stable until a cycle with tx_valid=1 and tx_ready=1 (handshake).
REQ-021 SEND handshake with count>1 -> tx_valid=0, addr=addr+1, count=count-1, read_select=new addr, go FETCH.
REQ-022 SEND handshake with count=1 -> tx_valid=0, go DONE.
REQ-023 DONE: done=1 for one clk, busy=0 from the next cycle, return to IDLE.
REQ-024 Address increment SHALL wrap modulo 2^ADDR_W (for ADDR_W=14, 16383 -> 0) with no error flag.
REQ-025 read_select SHALL be a registered output equal to the internal addr in all states.
REQ-026 tx_ready while tx_valid=0 SHALL have no effect.
REQ-027 A start asserted while busy=1, including in DONE, SHALL be ignored and not queued.
REQ-028 A start asserted in the cycle after done SHALL be accepted normally, since the FSM is in IDLE.
REQ-029 Bytes SHALL be emitted in ascending address order, exactly length bytes per dump.
REQ-030 Minimum cost SHALL be 3 clk per byte when tx_ready is held high.

Reset
REQ-031 While rst=1: state=IDLE; read_select=0, tx_data=0, tx_valid=0, busy=0, done=0; internal addr=0, count=0.
REQ-032 rst SHALL act asynchronously, so tx_valid and busy drop without waiting for a clk edge.
REQ-033 rst mid-dump SHALL abandon the transfer with no done pulse; the next start begins a fresh dump.

Verification
REQ-034 MEM holds 9 @1, 0x41 @2, 0x42 @3; start, base=1, length=3, tx_ready=1 -> tx_data 9, 0x41, 0x42, 3 clk apart; then done pulses once; busy falls.
REQ-035 base=16383, length=2 -> read_select 16383 then 0; two bytes sent in that order.
REQ-036 length=0 -> tx_valid never rises; busy is high for one cycle; done pulses once.
REQ-037 tx_ready held low 5 clk in SEND -> tx_valid and tx_data are held stable; the byte transfers on the first tx_ready=1 cycle.
REQ-038 Second start while busy -> ignored: byte count and done count match the first request only.
REQ-039 rst pulse (not clk-aligned) after the 1st byte of 3 -> all outputs 0 immediately; no done; a new start dumps correctly.
